// File: rtl/bg_io_regfile_if.sv
// IO bus bundle for the background register file: one-cycle write/read strobes,
// byte-enabled 32-bit write data and registered read data with a valid flag.
interface bg_io_regfile_if #(
    parameter int ADDR_W = 10
);
    // wr_en/rd_en are single-cycle strobes with no back-pressure: the register file
    // always accepts, and rvalid answers every rd_en exactly one cycle later.
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;

    modport master (
        output wr_en, rd_en, addr, be, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  wr_en, rd_en, addr, be, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/bg_io_regfile.sv
// CPU write side of the background registers plus BG2/BG3 affine reference points.
// Optional BG_LINE_LATCH_EN: CNT/HOFS/VOFS outputs come from per-line shadow copies.
module bg_io_regfile #(
    parameter int              ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] BASE_WADDR = 10'h002
) (
    input  logic        clock,
    input  logic        reset,
    bg_io_regfile_if.slave bus,
    input  logic        line_end,
    input  logic        vblank_start,
    output logic [15:0] bg0cnt, bg1cnt, bg2cnt, bg3cnt,
    output logic [15:0] bg0hofs, bg1hofs, bg2hofs, bg3hofs,
    output logic [15:0] bg0vofs, bg1vofs, bg2vofs, bg3vofs,
    output logic [15:0] bg2pa, bg2pb, bg2pc, bg2pd,
    output logic [15:0] bg3pa, bg3pb, bg3pc, bg3pd,
    output logic [27:0] bg2x, bg2y, bg3x, bg3y
);
    logic [15:0] cnt_q  [4], cnt_d  [4];
    logic [8:0]  hofs_q [4], hofs_d [4];
    logic [8:0]  vofs_q [4], vofs_d [4];
    logic [15:0] pa_q [2], pa_d [2], pb_q [2], pb_d [2];
    logic [15:0] pc_q [2], pc_d [2], pd_q [2], pd_d [2];
    logic [27:0] xr_q [2], xr_d [2], yr_q [2], yr_d [2];
    logic [27:0] xi_q [2], xi_d [2], yi_q [2], yi_d [2];
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic [ADDR_W-1:0] widx;
    logic              hit;
    logic [13:0]       wsel;

    function automatic logic [15:0] m16(input logic [15:0] o, input logic [15:0] w,
                                        input logic [1:0] e);
        return {e[1] ? w[15:8] : o[15:8], e[0] ? w[7:0] : o[7:0]};
    endfunction

    function automatic logic [8:0] m9(input logic [8:0] o, input logic [8:0] w,
                                      input logic [1:0] e);
        return {e[1] ? w[8] : o[8], e[0] ? w[7:0] : o[7:0]};
    endfunction

    function automatic logic [27:0] m28(input logic [27:0] o, input logic [27:0] w,
                                        input logic [3:0] e);
        return {e[3] ? w[27:24] : o[27:24], e[2] ? w[23:16] : o[23:16],
                e[1] ? w[15:8]  : o[15:8],  e[0] ? w[7:0]   : o[7:0]};
    endfunction

    // Word slots relative to BASE_WADDR: 0-1 CNT, 2-5 OFS, 6-9 BG2 affine, 10-13 BG3 affine.
    always_comb begin
        widx = bus.addr - BASE_WADDR;
        hit  = bus.wr_en && (bus.addr >= BASE_WADDR) && (widx < ADDR_W'(14));
        wsel = hit ? (14'd1 << widx[3:0]) : 14'd0;
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            cnt_d[n]  = cnt_q[n];
            hofs_d[n] = hofs_q[n];
            vofs_d[n] = vofs_q[n];
        end
        for (int b = 0; b < 2; b++) begin
            pa_d[b] = pa_q[b];
            pb_d[b] = pb_q[b];
            pc_d[b] = pc_q[b];
            pd_d[b] = pd_q[b];
            xr_d[b] = xr_q[b];
            yr_d[b] = yr_q[b];
            xi_d[b] = xi_q[b];
            yi_d[b] = yi_q[b];
        end
        rvalid_d = bus.rd_en;
        rdata_d  = 32'd0;

        // BG0/BG1 CNT bit 13 does not exist in hardware.
        if (wsel[0]) begin
            cnt_d[0] = m16(cnt_q[0], bus.wdata[15:0], bus.be[1:0]) & 16'hDFFF;
            cnt_d[1] = m16(cnt_q[1], bus.wdata[31:16], bus.be[3:2]) & 16'hDFFF;
        end
        if (wsel[1]) begin
            cnt_d[2] = m16(cnt_q[2], bus.wdata[15:0], bus.be[1:0]);
            cnt_d[3] = m16(cnt_q[3], bus.wdata[31:16], bus.be[3:2]);
        end
        for (int n = 0; n < 4; n++) begin
            if (wsel[2+n]) begin
                hofs_d[n] = m9(hofs_q[n], bus.wdata[8:0], bus.be[1:0]);
                vofs_d[n] = m9(vofs_q[n], bus.wdata[24:16], bus.be[3:2]);
            end
        end

        for (int b = 0; b < 2; b++) begin
            if (wsel[6+4*b]) begin
                pa_d[b] = m16(pa_q[b], bus.wdata[15:0], bus.be[1:0]);
                pb_d[b] = m16(pb_q[b], bus.wdata[31:16], bus.be[3:2]);
            end
            if (wsel[7+4*b]) begin
                pc_d[b] = m16(pc_q[b], bus.wdata[15:0], bus.be[1:0]);
                pd_d[b] = m16(pd_q[b], bus.wdata[31:16], bus.be[3:2]);
            end
            if (wsel[8+4*b]) xr_d[b] = m28(xr_q[b], bus.wdata[27:0], bus.be);
            if (wsel[9+4*b]) yr_d[b] = m28(yr_q[b], bus.wdata[27:0], bus.be);

            // CPU write beats vblank reload beats line step; the step uses the old PB/PD.
            if (wsel[8+4*b] && (|bus.be)) xi_d[b] = xr_d[b];
            else if (vblank_start)        xi_d[b] = xr_q[b];
            else if (line_end)            xi_d[b] = xi_q[b] + {{12{pb_q[b][15]}}, pb_q[b]};

            if (wsel[9+4*b] && (|bus.be)) yi_d[b] = yr_d[b];
            else if (vblank_start)        yi_d[b] = yr_q[b];
            else if (line_end)            yi_d[b] = yi_q[b] + {{12{pd_q[b][15]}}, pd_q[b]};
        end

        if (bus.rd_en) begin
            if (bus.addr == BASE_WADDR)                    rdata_d = {cnt_q[1], cnt_q[0]};
            else if (bus.addr == BASE_WADDR + ADDR_W'(1))  rdata_d = {cnt_q[3], cnt_q[2]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                cnt_q[n]  <= '0;
                hofs_q[n] <= '0;
                vofs_q[n] <= '0;
            end
            for (int b = 0; b < 2; b++) begin
                pa_q[b] <= '0;
                pb_q[b] <= '0;
                pc_q[b] <= '0;
                pd_q[b] <= '0;
                xr_q[b] <= '0;
                yr_q[b] <= '0;
                xi_q[b] <= '0;
                yi_q[b] <= '0;
            end
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                cnt_q[n]  <= cnt_d[n];
                hofs_q[n] <= hofs_d[n];
                vofs_q[n] <= vofs_d[n];
            end
            for (int b = 0; b < 2; b++) begin
                pa_q[b] <= pa_d[b];
                pb_q[b] <= pb_d[b];
                pc_q[b] <= pc_d[b];
                pd_q[b] <= pd_d[b];
                xr_q[b] <= xr_d[b];
                yr_q[b] <= yr_d[b];
                xi_q[b] <= xi_d[b];
                yi_q[b] <= yi_d[b];
            end
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    logic [15:0] cnt_o  [4];
    logic [8:0]  hofs_o [4];
    logic [8:0]  vofs_o [4];

`ifdef BG_LINE_LATCH_EN
    logic [15:0] cnt_s_q  [4];
    logic [8:0]  hofs_s_q [4];
    logic [8:0]  vofs_s_q [4];

    // Shadows capture the pre-edge register values, so a same-edge write waits a line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                cnt_s_q[n]  <= '0;
                hofs_s_q[n] <= '0;
                vofs_s_q[n] <= '0;
            end
        end else if (line_end || vblank_start) begin
            for (int n = 0; n < 4; n++) begin
                cnt_s_q[n]  <= cnt_q[n];
                hofs_s_q[n] <= hofs_q[n];
                vofs_s_q[n] <= vofs_q[n];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            cnt_o[n]  = cnt_s_q[n];
            hofs_o[n] = hofs_s_q[n];
            vofs_o[n] = vofs_s_q[n];
        end
    end
`else
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            cnt_o[n]  = cnt_q[n];
            hofs_o[n] = hofs_q[n];
            vofs_o[n] = vofs_q[n];
        end
    end
`endif

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;

    assign bg0cnt  = cnt_o[0];
    assign bg1cnt  = cnt_o[1];
    assign bg2cnt  = cnt_o[2];
    assign bg3cnt  = cnt_o[3];
    assign bg0hofs = {7'd0, hofs_o[0]};
    assign bg1hofs = {7'd0, hofs_o[1]};
    assign bg2hofs = {7'd0, hofs_o[2]};
    assign bg3hofs = {7'd0, hofs_o[3]};
    assign bg0vofs = {7'd0, vofs_o[0]};
    assign bg1vofs = {7'd0, vofs_o[1]};
    assign bg2vofs = {7'd0, vofs_o[2]};
    assign bg3vofs = {7'd0, vofs_o[3]};

    assign bg2pa = pa_q[0];
    assign bg2pb = pb_q[0];
    assign bg2pc = pc_q[0];
    assign bg2pd = pd_q[0];
    assign bg3pa = pa_q[1];
    assign bg3pb = pb_q[1];
    assign bg3pc = pc_q[1];
    assign bg3pd = pd_q[1];
    assign bg2x  = xi_q[0];
    assign bg2y  = yi_q[0];
    assign bg3x  = xi_q[1];
    assign bg3y  = yi_q[1];
endmodule

// File: tb/tb_bg_io_regfile.sv
// Bench for bg_io_regfile: vector table of bus/pulse inputs with expected outputs,
// plus directed sequences for line latching and mid-frame asynchronous reset.
module tb_bg_io_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line_end = 1'b0;
    logic vblank_start = 1'b0;
    logic [15:0] bg0cnt, bg1cnt, bg2cnt, bg3cnt;
    logic [15:0] bg0hofs, bg1hofs, bg2hofs, bg3hofs;
    logic [15:0] bg0vofs, bg1vofs, bg2vofs, bg3vofs;
    logic [15:0] bg2pa, bg2pb, bg2pc, bg2pd, bg3pa, bg3pb, bg3pc, bg3pd;
    logic [27:0] bg2x, bg2y, bg3x, bg3y;

    bg_io_regfile_if #(.ADDR_W(10)) bus ();

    bg_io_regfile #(.ADDR_W(10), .BASE_WADDR(10'h002)) dut (
        .clock(clk), .reset(rst), .bus(bus),
        .line_end(line_end), .vblank_start(vblank_start),
        .bg0cnt(bg0cnt), .bg1cnt(bg1cnt), .bg2cnt(bg2cnt), .bg3cnt(bg3cnt),
        .bg0hofs(bg0hofs), .bg1hofs(bg1hofs), .bg2hofs(bg2hofs), .bg3hofs(bg3hofs),
        .bg0vofs(bg0vofs), .bg1vofs(bg1vofs), .bg2vofs(bg2vofs), .bg3vofs(bg3vofs),
        .bg2pa(bg2pa), .bg2pb(bg2pb), .bg2pc(bg2pc), .bg2pd(bg2pd),
        .bg3pa(bg3pa), .bg3pb(bg3pb), .bg3pc(bg3pc), .bg3pd(bg3pd),
        .bg2x(bg2x), .bg2y(bg2y), .bg3x(bg3x), .bg3y(bg3y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        le;
        logic        vb;
        int          sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    localparam int S_NONE = 0, S_BG0CNT = 1, S_BG1CNT = 2, S_BG0HOFS = 3, S_BG0VOFS = 4,
                   S_RDATA = 5, S_RVALID = 6, S_BG2X = 7, S_BG2Y = 8, S_BG3X = 9,
                   S_BG2PB = 10, S_BG3CNT = 11, S_BG1HOFS = 12, S_BG3Y = 13, S_BG2CNT = 14;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_BG0CNT:  return {16'd0, bg0cnt};
            S_BG1CNT:  return {16'd0, bg1cnt};
            S_BG0HOFS: return {16'd0, bg0hofs};
            S_BG0VOFS: return {16'd0, bg0vofs};
            S_RDATA:   return bus.rdata;
            S_RVALID:  return {31'd0, bus.rvalid};
            S_BG2X:    return {4'd0, bg2x};
            S_BG2Y:    return {4'd0, bg2y};
            S_BG3X:    return {4'd0, bg3x};
            S_BG2PB:   return {16'd0, bg2pb};
            S_BG3CNT:  return {16'd0, bg3cnt};
            S_BG1HOFS: return {16'd0, bg1hofs};
            S_BG3Y:    return {4'd0, bg3y};
            S_BG2CNT:  return {16'd0, bg2cnt};
            default:   return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic rd, input logic [9:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata, input logic le,
                       input logic vb, input int sel, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.be = be; v.wdata = wdata;
        v.le = le; v.vb = vb; v.sel = sel; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [9:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic le, input logic vb);
        bus.wr_en = wr; bus.rd_en = rd; bus.addr = addr; bus.be = be;
        bus.wdata = wdata; line_end = le; vblank_start = vb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 10'd0, 4'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        idle();
        // CNT/OFS checks ride on a vblank pulse so they hold with or without line latching.
        add(1,0,10'd2,4'hF,32'hFFFF_FFFF,0,0,S_NONE,   32'h0);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG0CNT, 32'hDFFF);
        add(0,0,10'd0,4'h0,32'h0,        0,0,S_BG1CNT, 32'hDFFF);
        add(0,1,10'd2,4'h0,32'h0,        0,0,S_RDATA,  32'hDFFF_DFFF);
        add(0,1,10'd2,4'h0,32'h0,        0,0,S_RVALID, 32'h1);
        add(0,1,10'd4,4'h0,32'h0,        0,0,S_RDATA,  32'h0);
        add(0,0,10'd0,4'h0,32'h0,        0,0,S_RVALID, 32'h0);
        add(1,0,10'd4,4'h1,32'h0000_01AB,0,0,S_NONE,   32'h0);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG0HOFS,32'h00AB);
        add(1,0,10'd4,4'h2,32'h0000_01AB,0,0,S_NONE,   32'h0);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG0HOFS,32'h01AB);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG0VOFS,32'h0);
        add(1,0,10'd3,4'hC,32'h1234_5678,0,0,S_NONE,   32'h0);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG3CNT, 32'h1234);
        add(1,0,10'd3,4'h3,32'hFFFF_2000,0,0,S_NONE,   32'h0);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG2CNT, 32'h2000);
        add(0,1,10'd3,4'h0,32'h0,        0,0,S_RDATA,  32'h1234_2000);
        add(1,0,10'd2,4'h1,32'h0,        0,0,S_NONE,   32'h0);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG0CNT, 32'hDF00);
        add(1,0,10'd1,4'hF,32'h0,        0,0,S_NONE,   32'h0);
        add(1,0,10'd16,4'hF,32'h0,       0,0,S_NONE,   32'h0);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG0CNT, 32'hDF00);
        // BG2 X stepping by PB, vblank reload, combined pulses.
        add(1,0,10'd8,4'hC,32'h0100_0000,0,0,S_BG2PB,  32'h0100);
        add(1,0,10'd10,4'hF,32'h0000_1000,0,0,S_BG2X,  32'h1000);
        add(0,0,10'd0,4'h0,32'h0,        1,0,S_BG2X,   32'h1100);
        add(0,0,10'd0,4'h0,32'h0,        1,0,S_BG2X,   32'h1200);
        add(0,0,10'd0,4'h0,32'h0,        1,0,S_BG2X,   32'h1300);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG2X,   32'h1000);
        add(0,0,10'd0,4'h0,32'h0,        1,0,S_BG2X,   32'h1100);
        add(0,0,10'd0,4'h0,32'h0,        1,1,S_BG2X,   32'h1000);
        // BG2 Y with negative PD wraps modulo 2^28.
        add(1,0,10'd9,4'hC,32'hFF00_0000,0,0,S_NONE,   32'h0);
        add(1,0,10'd11,4'hF,32'h0000_0080,0,0,S_BG2Y,  32'h80);
        add(0,0,10'd0,4'h0,32'h0,        1,0,S_BG2Y,   32'hFFF_FF80);
        // X keeps 28 bits only; partial byte write reloads from the merged value.
        add(1,0,10'd10,4'hF,32'hFABC_DEF1,0,0,S_BG2X,  32'hABC_DEF1);
        add(1,0,10'd10,4'h1,32'h0000_0022,0,0,S_BG2X,  32'hABC_DE22);
        // BG3: write beats simultaneous vblank and line_end; PB write vs line_end.
        add(1,0,10'd12,4'hC,32'h0100_0000,0,0,S_NONE,  32'h0);
        add(1,0,10'd14,4'hF,32'h0000_2000,1,1,S_BG3X,  32'h2000);
        add(0,0,10'd0,4'h0,32'h0,        1,0,S_BG3X,   32'h2100);
        add(1,0,10'd12,4'hC,32'h0200_0000,1,0,S_BG3X,  32'h2200);
        add(0,0,10'd0,4'h0,32'h0,        1,0,S_BG3X,   32'h2400);
        add(1,0,10'd14,4'h0,32'hFFFF_FFFF,0,0,S_BG3X,  32'h2400);
        add(0,0,10'd0,4'h0,32'h0,        0,1,S_BG3X,   32'h2000);
        add(0,0,10'd0,4'h0,32'h0,        1,0,S_BG3Y,   32'h0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bg0cnt", obs(S_BG0CNT), 32'h0);
        check("reset_bg2x",   obs(S_BG2X),   32'h0);
        check("reset_rvalid", obs(S_RVALID), 32'h0);
        check("reset_rdata",  obs(S_RDATA),  32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].be, tbl[i].wdata,
                  tbl[i].le, tbl[i].vb);
            @(posedge clk);
            #1;
            if (tbl[i].sel != S_NONE)
                check($sformatf("vec%0d", i), obs(tbl[i].sel), tbl[i].exp);
        end
        idle();

        // BG1HOFS write mid-line.
        drive(1'b1, 1'b0, 10'd5, 4'h3, 32'h0000_0005, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        idle();
`ifdef BG_LINE_LATCH_EN
        check("latch_after_write", obs(S_BG1HOFS), 32'h0);
        @(posedge clk);
        #1;
        check("latch_mid_line", obs(S_BG1HOFS), 32'h0);
`else
        check("direct_after_write", obs(S_BG1HOFS), 32'h5);
        @(posedge clk);
        #1;
        check("direct_mid_line", obs(S_BG1HOFS), 32'h5);
`endif
        drive(1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        idle();
        check("hofs_after_line", obs(S_BG1HOFS), 32'h5);

        // Mid-frame asynchronous reset, with a pulse held across it.
        @(negedge clk);
        line_end = 1'b1;
        rst = 1'b1;
        #1;
        check("async_rst_bg3x",   obs(S_BG3X),   32'h0);
        check("async_rst_bg0cnt", obs(S_BG0CNT), 32'h0);
        check("async_rst_bg1hofs", obs(S_BG1HOFS), 32'h0);
        @(posedge clk);
        #1;
        line_end = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_bg2x", obs(S_BG2X), 32'h0);
        check("post_rst_bg2pb", obs(S_BG2PB), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
